neuron_feeder: RTL and testbench
================================

// Module: neuron_feeder
// PURPOSE
//  Upstream sequencer for the time-multiplexed neuron stage. Buffers one input
//  activation vector as BEATS words of PW bits. Replays that vector once per
//  neuron, pairing each word with weights read from an external sync RAM.
//  Drives the neuron's x/w/thresh/valid_in/last lanes and pulses done per image.
// PARAMETERS
//  PW          8    bits per beat (neuron lane width)
//  THRESH_W    16   threshold width
//  IN_BITS     32   input vector bits; must be a multiple of PW (elab $error)
//  NUM_NEURONS 3    neurons evaluated per image
//  BEATS       IN_BITS/PW (derived); WADDR_W=$clog2(NUM_NEURONS*BEATS), NADDR_W=$clog2(NUM_NEURONS)
// PORTS
//  clk        in   1         clock
//  rst        in   1         async active-high reset
//  in_valid   in   1         input beat valid
//  in_ready   out  1         feeder accepts input beat
//  in_data    in   PW        input activation beat, beat 0 first
//  w_addr     out  WADDR_W   weight RAM address = n*BEATS+b
//  w_rd       out  1         weight RAM read enable
//  w_data     in   PW        weight word, valid 1 cycle after w_rd
//  t_addr     out  NADDR_W   threshold RAM address = n
//  t_data     in   THRESH_W  threshold, valid 1 cycle after first w_rd of neuron n
//  x          out  PW        activation beat to neuron
//  w          out  PW        weight beat to neuron
//  thresh     out  THRESH_W  threshold, held for all beats of a neuron
//  valid_in   out  1         beat valid to neuron
//  last       out  1         final beat of current neuron
//  neuron_idx out  NADDR_W   index of neuron whose beats are on x/w
//  done       out  1         1-cycle pulse after last beat of last neuron
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; w_rd, valid_in, last, done=0; x, w, thresh,
//   neuron_idx, w_addr, t_addr=0; beat/neuron counters=0; buffer contents don't-care.
//  FSM IDLE -> LOAD -> RUN -> FLUSH -> IDLE.
//  IDLE/LOAD: in_ready=1. A beat transfers on in_valid&in_ready into buf[b]; b++.
//   The first beat moves IDLE->LOAD. The BEATS-th beat moves to RUN, with b=0 and n=0.
//   in_ready=0 from the cycle after the final beat until the return to IDLE.
//  RUN, each cycle: w_rd=1, w_addr=running counter (+1 per cycle, no multiplier),
//   t_addr=n; register x_q<=buf[b], last_q<=(b==BEATS-1), n_q<=n.
//   b wraps at BEATS-1 and n increments. After b=BEATS-1 of n=NUM_NEURONS-1 -> FLUSH.
//  Output stage (1-cycle RAM latency): the cycle after each RUN cycle drives
//   valid_in=1, x=x_q, w=w_data, last=last_q, neuron_idx=n_q.
//   thresh is loaded from t_data on the output cycle of beat 0 and held otherwise.
//  Latency: first valid_in 2 cycles after the final input transfer. Then
//   NUM_NEURONS*BEATS back-to-back valid_in cycles, no bubbles, no backpressure.
//  FLUSH: lasts 1 cycle (final output beat); done=1 in the cycle after it; -> IDLE.
//   The next image can begin transferring in the cycle done is high.
//  Input beats presented while in_ready=0 are not consumed; the upstream holds them.
//  BEATS=1: every valid_in has last=1. NUM_NEURONS=1: single pass then done.
//  w_addr returns to 0 at start of each RUN; counters never exceed their max.
//  rst asserted mid-LOAD/RUN: abort immediately to reset values. No partial
//   done or valid_in may follow; the next image restarts at beat 0.
// TESTING
//  PW=8,IN_BITS=32,N=3; load A5,3C,FF,00 -> 12 valid_in; x seq A5,3C,FF,00 x3; last on 4,8,12
//  Weight RAM holds addr as data -> w seq 0..11; w_addr 0..11 with w_rd 12 cycles contiguous
//  thresh RAM {10,20,30} -> thresh=10 beats1-4, 20 beats5-8, 30 beats9-12; neuron_idx 0,1,2
//  in_valid toggled 1010... during LOAD -> buf order preserved; in_ready=0 throughout RUN/FLUSH
//  Back-to-back images: 2nd image presented with in_valid held -> first beat accepted on done cycle
//  rst pulsed at RUN beat 5 -> all outputs 0 next edge; no done; a fresh load yields full 12 beats

Source files
------------

// File: rtl/neuron_feeder.sv
// Buffers one activation vector and replays it once per neuron,
// pairing each beat with weight/threshold words from external sync RAMs.
module neuron_feeder #(
  parameter int PW          = 8,
  parameter int THRESH_W    = 16,
  parameter int IN_BITS     = 32,
  parameter int NUM_NEURONS = 3,
  localparam int BEATS   = IN_BITS / PW,
  localparam int WADDR_W = (NUM_NEURONS * BEATS > 1) ?
                           $clog2(NUM_NEURONS * BEATS) : 1,
  localparam int NADDR_W = (NUM_NEURONS > 1) ?
                           $clog2(NUM_NEURONS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PW-1:0]       in_data,
  output logic [WADDR_W-1:0]  w_addr,
  output logic                w_rd,
  input  logic [PW-1:0]       w_data,
  output logic [NADDR_W-1:0]  t_addr,
  input  logic [THRESH_W-1:0] t_data,
  output logic [PW-1:0]       x,
  output logic [PW-1:0]       w,
  output logic [THRESH_W-1:0] thresh,
  output logic                valid_in,
  output logic                last,
  output logic [NADDR_W-1:0]  neuron_idx,
  output logic                done
);

  if (IN_BITS % PW != 0) begin : g_bad_width
    $error("IN_BITS must be a multiple of PW");
  end

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0]      B_MAX = BW'(BEATS - 1);
  localparam logic [NADDR_W-1:0] N_MAX = NADDR_W'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} state_e;

  state_e               state_q, state_d;
  logic [BW-1:0]        b_q, b_d;
  logic [NADDR_W-1:0]   n_q, n_d;
  logic [WADDR_W-1:0]   wa_q, wa_d;
  logic [PW-1:0]        x_q, x_d;
  logic                 last_q, last_d;
  logic                 vld_q, vld_d;
  logic                 first_q, first_d;
  logic [NADDR_W-1:0]   nidx_q, nidx_d;
  logic [THRESH_W-1:0]  th_q, th_d;
  logic                 done_q, done_d;
  logic [PW-1:0]        mem_q [BEATS];
  logic                 accept;

  assign in_ready = (state_q == IDLE) || (state_q == LOAD);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    n_d     = n_q;
    wa_d    = wa_q;
    x_d     = x_q;
    nidx_d  = nidx_q;
    vld_d   = 1'b0;
    last_d  = 1'b0;
    first_d = 1'b0;
    done_d  = (state_q == FLUSH);
    unique case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          if (b_q == B_MAX) begin
            state_d = RUN;
            b_d     = '0;
            n_d     = '0;
            wa_d    = '0;
          end else begin
            state_d = LOAD;
            b_d     = b_q + BW'(1);
          end
        end
      end
      RUN: begin
        vld_d   = 1'b1;
        x_d     = mem_q[b_q];
        last_d  = (b_q == B_MAX);
        first_d = (b_q == '0);
        nidx_d  = n_q;
        wa_d    = wa_q + WADDR_W'(1);
        if (b_q == B_MAX) begin
          b_d = '0;
          if (n_q == N_MAX) begin
            state_d = FLUSH;
            n_d     = '0;
            wa_d    = '0;
          end else begin
            n_d = n_q + NADDR_W'(1);
          end
        end else begin
          b_d = b_q + BW'(1);
        end
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Threshold word arrives with beat 0 of each neuron and is held after.
  assign th_d = (vld_q && first_q) ? t_data : th_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      b_q     <= '0;
      n_q     <= '0;
      wa_q    <= '0;
      x_q     <= '0;
      last_q  <= 1'b0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      nidx_q  <= '0;
      th_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      n_q     <= n_d;
      wa_q    <= wa_d;
      x_q     <= x_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      first_q <= first_d;
      nidx_q  <= nidx_d;
      th_q    <= th_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[b_q] <= in_data;
  end

  assign w_rd       = (state_q == RUN);
  assign w_addr     = wa_q;
  assign t_addr     = n_q;
  assign x          = x_q;
  assign w          = vld_q ? w_data : '0;
  assign thresh     = th_d;
  assign valid_in   = vld_q;
  assign last       = last_q;
  assign neuron_idx = nidx_q;
  assign done       = done_q;

endmodule

// File: tb/tb_neuron_feeder.sv
// Bench for neuron_feeder: directed table, back-to-back, reset abort,
// and random images against a beat-level reference model.
module tb_neuron_feeder;
  localparam int PW = 8;
  localparam int TW = 16;
  localparam int NB = 4;
  localparam int NN = 3;
  localparam int NT = NB * NN;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic [3:0]    w_addr;
  logic          w_rd;
  logic [PW-1:0] w_data = '0;
  logic [1:0]    t_addr;
  logic [TW-1:0] t_data = '0;
  logic [PW-1:0] x;
  logic [PW-1:0] w;
  logic [TW-1:0] thresh;
  logic          valid_in;
  logic          last;
  logic [1:0]    neuron_idx;
  logic          done;

  neuron_feeder #(
    .PW(PW), .THRESH_W(TW), .IN_BITS(32), .NUM_NEURONS(NN)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_addr(w_addr), .w_rd(w_rd), .w_data(w_data),
    .t_addr(t_addr), .t_data(t_data),
    .x(x), .w(w), .thresh(thresh),
    .valid_in(valid_in), .last(last),
    .neuron_idx(neuron_idx), .done(done)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] wram [NT];
  logic [TW-1:0] tram [NN];

  always @(posedge clk) begin
    if (w_rd) begin
      w_data <= wram[w_addr];
      t_data <= tram[t_addr];
    end
  end

  typedef struct {
    logic [PW-1:0] x;
    logic [PW-1:0] w;
    logic [TW-1:0] th;
    logic          last;
    logic [1:0]    idx;
  } beat_t;

  beat_t dir_tab [NT];
  beat_t exp_tab [NT];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected beat k: activation k mod BEATS, weight word k,
  // threshold of neuron k / BEATS.
  function automatic void model(input logic [PW-1:0] v [NB]);
    for (int k = 0; k < NT; k++) begin
      exp_tab[k].x    = v[k % NB];
      exp_tab[k].w    = wram[k];
      exp_tab[k].th   = tram[k / NB];
      exp_tab[k].last = (k % NB) == NB - 1;
      exp_tab[k].idx  = 2'(k / NB);
    end
  endfunction

  // mode 0: in_valid solid, 1: alternating 1010, 2: random
  task automatic load(input logic [PW-1:0] v [NB], input int start,
                      input int mode, input bit hold,
                      input logic [PW-1:0] nxt);
    int i;
    int cyc;
    i = start;
    cyc = 0;
    while (i < NB && cyc < 200) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0: in_valid = 1'b1;
        1: in_valid = (cyc % 2) == 1;
        default: in_valid = ($urandom % 2) == 1;
      endcase
      in_data = in_valid ? v[i] : PW'($urandom);
      if (in_valid && in_ready) i++;
    end
    if (i < NB) chk("load_timeout", i, NB);
    @(negedge clk);
    if (hold) begin
      in_valid = 1'b1;
      in_data  = nxt;
    end else begin
      in_valid = 1'b0;
    end
    chk("ready_low_after_load", in_ready, 0);
    chk("w_rd_first", w_rd, 1);
    chk("w_addr_first", w_addr, 0);
  endtask

  task automatic collect(input bit b2b);
    for (int k = 0; k < NT; k++) begin
      @(negedge clk);
      chk($sformatf("valid_in[%0d]", k), valid_in, 1);
      chk($sformatf("x[%0d]", k), x, exp_tab[k].x);
      chk($sformatf("w[%0d]", k), w, exp_tab[k].w);
      chk($sformatf("thresh[%0d]", k), thresh, exp_tab[k].th);
      chk($sformatf("last[%0d]", k), last, exp_tab[k].last);
      chk($sformatf("idx[%0d]", k), neuron_idx, exp_tab[k].idx);
      chk($sformatf("in_ready[%0d]", k), in_ready, 0);
      chk($sformatf("done_early[%0d]", k), done, 0);
      if (k < NT - 1) begin
        chk($sformatf("w_rd[%0d]", k), w_rd, 1);
        chk($sformatf("w_addr[%0d]", k), w_addr, k + 1);
        chk($sformatf("t_addr[%0d]", k), t_addr, (k + 1) / NB);
      end else begin
        chk("w_rd_end", w_rd, 0);
      end
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("valid_after", valid_in, 0);
    chk("ready_on_done", in_ready, 1);
    if (!b2b) begin
      @(negedge clk);
      chk("done_clear", done, 0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid_in"}, valid_in, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_w_rd"}, w_rd, 0);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_w"}, w, 0);
    chk({tag, "_thresh"}, thresh, 0);
    chk({tag, "_idx"}, neuron_idx, 0);
    chk({tag, "_w_addr"}, w_addr, 0);
    chk({tag, "_t_addr"}, t_addr, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  logic [PW-1:0] va [NB];
  logic [PW-1:0] vb [NB];
  logic [PW-1:0] vr [NB];

  initial begin
    dir_tab[0]  = '{8'hA5, 8'd0,  16'd10, 1'b0, 2'd0};
    dir_tab[1]  = '{8'h3C, 8'd1,  16'd10, 1'b0, 2'd0};
    dir_tab[2]  = '{8'hFF, 8'd2,  16'd10, 1'b0, 2'd0};
    dir_tab[3]  = '{8'h00, 8'd3,  16'd10, 1'b1, 2'd0};
    dir_tab[4]  = '{8'hA5, 8'd4,  16'd20, 1'b0, 2'd1};
    dir_tab[5]  = '{8'h3C, 8'd5,  16'd20, 1'b0, 2'd1};
    dir_tab[6]  = '{8'hFF, 8'd6,  16'd20, 1'b0, 2'd1};
    dir_tab[7]  = '{8'h00, 8'd7,  16'd20, 1'b1, 2'd1};
    dir_tab[8]  = '{8'hA5, 8'd8,  16'd30, 1'b0, 2'd2};
    dir_tab[9]  = '{8'h3C, 8'd9,  16'd30, 1'b0, 2'd2};
    dir_tab[10] = '{8'hFF, 8'd10, 16'd30, 1'b0, 2'd2};
    dir_tab[11] = '{8'h00, 8'd11, 16'd30, 1'b1, 2'd2};
    va = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    vb = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < NT; k++) wram[k] = PW'(k);
    tram = '{16'd10, 16'd20, 16'd30};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Directed image, solid and alternating in_valid
    exp_tab = dir_tab;
    load(va, 0, 0, 1'b0, '0);
    collect(1'b0);
    load(va, 0, 1, 1'b0, '0);
    collect(1'b0);

    // Back-to-back: next image's first beat held through RUN/FLUSH
    load(va, 0, 0, 1'b1, vb[0]);
    collect(1'b1);
    model(vb);
    load(vb, 1, 0, 1'b0, '0);
    collect(1'b0);

    // Reset asserted on output beat 5
    exp_tab = dir_tab;
    load(va, 0, 0, 1'b0, '0);
    for (int k = 0; k < 5; k++) @(negedge clk);
    chk("pre_rst_x", x, 8'hA5);
    rst = 1'b1;
    #1;
    chk_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_valid", valid_in, 0);
      chk("abort_no_done", done, 0);
    end
    load(va, 0, 0, 1'b0, '0);
    collect(1'b0);

    // Random images with random RAM contents
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NT; k++) wram[k] = PW'($urandom);
      for (int k = 0; k < NN; k++) tram[k] = TW'($urandom);
      for (int k = 0; k < NB; k++) vr[k] = PW'($urandom);
      model(vr);
      load(vr, 0, 2, 1'b0, '0);
      collect(1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
